// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared PS/2 constants, decoder state type and frame check helper
package ps2_pkg;

  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam int         FRAME_LEN = 11;
  localparam logic [3:0] LAST_BIT  = 4'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } ps2_state_t;

  // bits = {parity, D7..D0, start} as shifted in; stop is the bit on the final edge
  function automatic logic frame_ok(input logic [9:0] bits, input logic stop);
    return (bits[0] == 1'b0) && (stop == 1'b1) && (^bits[9:1] == 1'b1);
  endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// rtl/ps2_frame_rx.sv - PS/2 bit-level deserializer with synchronizers, frame check and timeout
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       rx_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic          clk_s1, clk_s2, clk_s3;
  logic          data_s1, data_s2;
  logic          fall;
  logic [3:0]    bit_cnt;
  logic [9:0]    shift;
  logic [TW-1:0] timer;
  logic          timed_out;

  // Synchronizers reset high so a reset never fabricates a falling edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_s1  <= 1'b1;
      clk_s2  <= 1'b1;
      clk_s3  <= 1'b1;
      data_s1 <= 1'b1;
      data_s2 <= 1'b1;
    end else begin
      clk_s1  <= ps2_clk;
      clk_s2  <= clk_s1;
      clk_s3  <= clk_s2;
      data_s1 <= ps2_data;
      data_s2 <= data_s1;
    end
  end

  assign fall      = clk_s3 & ~clk_s2;
  assign timed_out = (bit_cnt != 4'd0) && !fall && (timer == TIMER_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer <= '0;
    end else if (fall || bit_cnt == 4'd0 || timed_out) begin
      timer <= '0;
    end else begin
      timer <= timer + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt  <= 4'd0;
      shift    <= '0;
      rx_byte  <= 8'h00;
      rx_valid <= 1'b0;
      rx_err   <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      rx_err   <= 1'b0;
      if (fall) begin
        if (bit_cnt == LAST_BIT) begin
          bit_cnt <= 4'd0;
          if (frame_ok(shift, data_s2)) begin
            rx_byte  <= shift[8:1];
            rx_valid <= 1'b1;
          end else begin
            rx_err <= 1'b1;
          end
        end else begin
          shift   <= {data_s2, shift[9:1]};
          bit_cnt <= bit_cnt + 4'd1;
        end
      end else if (timed_out) begin
        bit_cnt <= 4'd0;
      end
    end
  end

endmodule

// File: rtl/ps2_key_tracker.sv
// rtl/ps2_key_tracker.sv - PS/2 keyboard tracker: frame receiver plus make/break/extended decoder
module ps2_key_tracker
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] my_data,
  output logic       pre,
  output logic       preflag,
  output logic       ready,
  output logic       frame_err
);

  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       rx_err;

  ps2_state_t state_q, state_d;
  logic [7:0] data_d;
  logic       pre_d, preflag_d;

  ps2_frame_rx #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx (
    .clk     (clk),
    .rst     (rst),
    .ps2_clk (ps2_clk),
    .ps2_data(ps2_data),
    .rx_byte (rx_byte),
    .rx_valid(rx_valid),
    .rx_err  (rx_err)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else if (rx_valid) begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (rx_byte == PS2_EXT)        state_d = ST_EXT;
        else if (rx_byte == PS2_BREAK) state_d = ST_BRK;
        else                           state_d = ST_IDLE;
      end
      ST_EXT: begin
        if (rx_byte == PS2_BREAK)      state_d = ST_EXT_BRK;
        else if (rx_byte == PS2_EXT)   state_d = ST_EXT;
        else                           state_d = ST_IDLE;
      end
      ST_BRK, ST_EXT_BRK: state_d = ST_IDLE;
      default:            state_d = ST_IDLE;
    endcase
  end

  // Next output values; prefixes leave the held-key flags untouched
  always_comb begin
    data_d    = my_data;
    pre_d     = pre;
    preflag_d = preflag;
    unique case (state_q)
      ST_IDLE, ST_EXT: begin
        if (rx_byte == PS2_BREAK) begin
          data_d = PS2_BREAK;
        end else if (rx_byte != PS2_EXT) begin
          data_d    = rx_byte;
          pre_d     = 1'b1;
          preflag_d = (state_q == ST_EXT);
        end
      end
      ST_BRK, ST_EXT_BRK: begin
        data_d    = rx_byte;
        pre_d     = 1'b0;
        preflag_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      my_data   <= 8'h00;
      pre       <= 1'b0;
      preflag   <= 1'b0;
      ready     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      ready     <= rx_valid;
      frame_err <= rx_err;
      if (rx_valid) begin
        my_data <= data_d;
        pre     <= pre_d;
        preflag <= preflag_d;
      end
    end
  end

endmodule
